arith_shift_sequencer: RTL and testbench
========================================

Name: arith_shift_sequencer

Overview:
Multi-cycle controller that performs arithmetic right shifts of any amount using a 0-3-bit-per-cycle arithmetic right-shift datapath. It instantiates one such shifter stage, holding the working operand in a register and driving the stage's 2-bit control each cycle. It sits between a producer and a consumer with valid/ready handshakes on both sides. Results are sign-correct: floor(x / 2^amt), two's complement.

Parameters:
N, 8, data width in bits (N >= 4)
AW, 4, width of the shift-amount input; amounts 0 to 2^AW-1 accepted

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer offers operand and amount
in_ready  output  1  block can accept; high only in IDLE
in_data  input  N  signed operand
in_amt  input  AW  unsigned shift amount
out_valid  output  1  result available; high only in DONE
out_ready  input  1  consumer accepts result
out_data  output  N  signed result, registered
busy  output  1  high in SHIFT or DONE

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, internal remaining count=0. Any in-flight operation is discarded; no partial result is emitted.
- Effective amount eff = min(in_amt, N), computed at accept. Amounts >= N yield all-sign-bit results (0x00 or all-ones).
- FSM states: IDLE, SHIFT, DONE.
- IDLE: accept when in_valid & in_ready. Load the working register with in_data and rem with eff. If eff=0, go to DONE; otherwise go to SHIFT.
- SHIFT: step = min(rem,3). Drive shifter control = step. Working register <= shifter output. rem <= rem-step. If rem <= 3, go to DONE on the same edge; otherwise stay in SHIFT.
- DONE: out_data = working register, out_valid=1. On out_valid & out_ready, go to IDLE. No new accept occurs in the same cycle.
- Latency: with the accept edge as edge 0, out_valid is high after edge ceil(eff/3).
- Throughput: at most one operation per ceil(eff/3)+2 cycles.
- Backpressure: out_ready low holds DONE indefinitely; out_data stable; in_ready=0.
- in_data and in_amt are sampled only at accept. Later changes are ignored.
- in_valid may toggle freely outside IDLE with no effect.
- out_data is held after the handshake until the next result overwrites it.

Optional Feature:
Macro ARITH_SHIFT_ROUND_EN.
- Defined: the block tracks the last bit shifted out. For a step s, this is bit s-1 of the pre-step working value. On entry to DONE, that bit is added to the working value, giving round-half-up: floor(x/2^eff + 0.5).
- No overflow is possible for eff >= 1. For eff=0, no rounding is applied.
- Adds one flop; latency is unchanged.
- Undefined: pure floor (truncating) result; no extra logic.

Test Plan:
1. N=8: in_data=0x80, in_amt=5 -> out_data=0xFC; out_valid high after edge 2; in_ready low during SHIFT and DONE.
2. in_data=0x7F, in_amt=0 -> out_data=0x7F with out_valid high on the cycle right after accept; in_data=0x35, in_amt=3 -> 0x06 after 1 SHIFT cycle.
3. Clamp: in_data=0xB4, in_amt=15 -> 0xFF after 3 SHIFT cycles (eff=8); in_data=0x35, in_amt=9 -> 0x00; in_data=0xB4, in_amt=7 -> 0xFF after 3 cycles.
4. Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 and changing in_data. Required: out_data stable, out_valid held, in_ready=0, no new accept. After out_ready=1: IDLE next cycle, then the next operand is accepted.
5. Reset: assert rst_n=0 mid-SHIFT of 0x80 amt 7. Required: immediate IDLE, out_valid=0, out_data=0, busy=0. After release, 0x40 amt 2 -> 0x10 is correct.
6. ARITH_SHIFT_ROUND_EN: 0x05 amt 1 -> 0x03 (0x02 without macro); 0xFB amt 1 -> 0xFE (0xFD without); 0x80 amt 8 -> 0x00 (0xFF without).

Source files
------------

// File: rtl/arith_shift_sequencer.sv
// arith_shift_sequencer
//
// Performs an arithmetic right shift of any amount by iterating a single
// 0..3-bit arithmetic right-shift stage. The working operand is held in a
// register and the stage control is driven each cycle, so the result is
// floor(x / 2^amt) in two's complement. Amounts of N or more are clamped to
// N, which yields an all-sign-bit result.
//
// Parameters:
//   N   data width in bits (N >= 4)
//   AW  width of the shift-amount input
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   producer offers operand and amount
//   in_ready   block can accept (IDLE only)
//   in_data    signed operand, sampled at accept
//   in_amt     unsigned shift amount, sampled at accept
//   out_valid  result available (DONE only)
//   out_ready  consumer accepts result
//   out_data   signed result, registered, held until the next result
//   busy       high while shifting or holding a result
//
// Optional build macro:
//   ARITH_SHIFT_ROUND_EN  round half up: the last bit shifted out is added
//                         to the result when it is written, giving
//                         floor(x / 2^amt + 0.5). No rounding for amt = 0.

module arith_shift_stage #(
    parameter int N = 8
) (
    input  logic signed [N-1:0] d,
    input  logic        [1:0]   sh,
    output logic signed [N-1:0] q
);
    assign q = d >>> sh;
endmodule

module arith_shift_sequencer #(
    parameter int N  = 8,
    parameter int AW = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [N-1:0] in_data,
    input  logic [AW-1:0]       in_amt,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [N-1:0] out_data,
    output logic                busy
);
    // rem must hold the clamped amount, which can be N itself
    localparam int RW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state, next_state;
    logic signed [N-1:0] work;
    logic signed [N-1:0] shift_q;
    logic [RW-1:0]       rem;
    logic [RW-1:0]       eff;
    logic [1:0]          step;
    logic                last_step;
    logic                accept;

    function automatic logic [RW-1:0] clamp_amt(input logic [AW-1:0] a);
        if (32'(a) >= N) return RW'(N);
        else             return RW'(a);
    endfunction

`ifdef ARITH_SHIFT_ROUND_EN
    // Bit s-1 of the pre-step value is the last bit the step discards.
    function automatic logic lost_bit(input logic signed [N-1:0] v,
                                      input logic [1:0]          s);
        case (s)
            2'd1:    return v[0];
            2'd2:    return v[1];
            2'd3:    return v[2];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic signed [N-1:0] round_up(input logic signed [N-1:0] v,
                                                     input logic                b);
        // Cannot overflow: after a shift of at least one bit the positive
        // range has headroom for +1.
        return v + $signed({{(N-1){1'b0}}, b});
    endfunction
`endif

    assign eff       = clamp_amt(in_amt);
    assign step      = (rem >= RW'(3)) ? 2'd3 : rem[1:0];
    assign last_step = (rem <= RW'(3));

    arith_shift_stage #(.N(N)) u_stage (
        .d  (work),
        .sh (step),
        .q  (shift_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    next_state = (eff == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_step) next_state = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Working register, remaining count and result register. The result is
    // written only on entry to DONE, so it stays stable through backpressure
    // and after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work     <= '0;
            rem      <= '0;
            out_data <= '0;
        end else if (accept) begin
            work <= in_data;
            rem  <= eff;
            if (eff == '0) out_data <= in_data;
        end else if (state == SHIFT) begin
            work <= shift_q;
            rem  <= rem - RW'(step);
            if (last_step) begin
`ifdef ARITH_SHIFT_ROUND_EN
                out_data <= round_up(shift_q, lost_bit(work, step));
`else
                out_data <= shift_q;
`endif
            end
        end
    end

endmodule

// File: tb/tb_arith_shift_sequencer.sv
// Testbench for arith_shift_sequencer (N=8, AW=4): directed cases from the
// block's feature list followed by randomized operations, each compared with
// an arithmetic reference model (floor division by a power of two, or round
// half up when ARITH_SHIFT_ROUND_EN is defined).

module tb_arith_shift_sequencer;
    localparam int N  = 8;
    localparam int AW = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic [AW-1:0] in_amt;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic          busy;

    int n_tests;
    int n_fail;

    arith_shift_sequencer #(.N(N), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int floor_div_pow2(input int x, input int e);
        int d;
        int q;
        d = 1 << e;
        q = x / d;
        if (x < 0 && q * d != x) q = q - 1;
        return q;
    endfunction

    function automatic logic [N-1:0] model(input logic [N-1:0] x, input logic [AW-1:0] amt);
        int xv;
        int e;
        int r;
        xv = int'($signed(x));
        e  = (int'(amt) > N) ? N : int'(amt);
`ifdef ARITH_SHIFT_ROUND_EN
        if (e > 0) r = floor_div_pow2(2 * xv + (1 << e), e + 1);
        else       r = xv;
`else
        r = floor_div_pow2(xv, e);
`endif
        return N'(r);
    endfunction

    // One full transaction: accept, shift, optional backpressure, handshake.
    // Entered and left at #1 after a rising edge.
    task automatic do_op(input logic [N-1:0] x, input logic [AW-1:0] amt, input int hold);
        logic [N-1:0] exp_d;
        int           eff;
        int           exp_lat;
        int           lat;
        int           w;
        eff     = (int'(amt) > N) ? N : int'(amt);
        exp_d   = model(x, amt);
        exp_lat = (eff + 2) / 3;

        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check("idle_ready", {31'b0, in_ready}, 32'd1);

        in_valid = 1'b1;
        in_data  = x;
        in_amt   = amt;
        @(posedge clk); #1;

        lat = 0;
        while (!out_valid && lat < 20) begin
            check("shift_flags", {30'b0, in_ready, busy}, 32'b01);
            in_valid  = 1'($urandom);
            in_data   = N'($urandom);
            in_amt    = AW'($urandom);
            out_ready = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        check("out_data", {24'b0, out_data}, {24'b0, exp_d});
        check("done_flags", {30'b0, in_ready, busy}, 32'b01);

        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = N'($urandom);
            in_amt    = AW'($urandom);
            @(posedge clk); #1;
            check("hold_valid", {31'b0, out_valid}, 32'd1);
            check("hold_data", {24'b0, out_data}, {24'b0, exp_d});
            check("hold_ready", {31'b0, in_ready}, 32'd0);
        end

        out_ready = 1'b1;
        in_valid  = 1'($urandom);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("after_hs", {29'b0, out_valid, in_ready, busy}, 32'b010);
        check("data_kept", {24'b0, out_data}, {24'b0, exp_d});
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_out_data", {24'b0, out_data}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        do_op(8'h80, 4'd5, 0);
        do_op(8'h7F, 4'd0, 0);
        do_op(8'h35, 4'd3, 0);
        do_op(8'hB4, 4'd15, 0);
        do_op(8'h35, 4'd9, 0);
        do_op(8'hB4, 4'd7, 0);
        do_op(8'h23, 4'd4, 5);
        do_op(8'h05, 4'd1, 0);
        do_op(8'hFB, 4'd1, 0);
        do_op(8'h80, 4'd8, 1);
        do_op(8'h7F, 4'd8, 2);

        // Reset in the middle of a shift
        in_valid = 1'b1;
        in_data  = 8'h80;
        in_amt   = 4'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_out_data", {24'b0, out_data}, 32'd0);
        @(posedge clk); #1;
        check("rst_hold_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_valid", {31'b0, out_valid}, 32'd0);
        do_op(8'h40, 4'd2, 0);

        // Randomized operations
        for (int k = 0; k < 200; k++) begin
            do_op(N'($urandom), AW'($urandom), $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
